// File: rtl/keypad_scanner_pkg.sv
// Shared key codes, default scan timing and the raw scan-result type for
// the 4x4 keypad scanners that feed img_generator.
package keypad_scanner_pkg;

  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_UP   = 4'd2;
  localparam logic [3:0] KEY_DOWN = 4'd8;

  localparam int KEYPAD_SCAN_DIV       = 25000;
  localparam int KEYPAD_DEBOUNCE_SCANS = 4;

  // One full-scan result; hit=0 means no key or a rejected multi-key press.
  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } raw_t;

  localparam raw_t RAW_NONE = '{hit: 1'b0, code: KEY_NONE};

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the debounced key outputs of one player's scanner.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] keys;
  logic       key_valid;
  logic       key_pressed;

  modport master (
    input  row_n,
    output col_n, keys, key_valid, key_pressed
  );

  modport slave (
    output row_n,
    input  col_n, keys, key_valid, key_pressed
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs, with a synchronous
// active-low reset to a chosen idle value.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge input and the two stages really form a pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scans a 4x4 keypad, rejects multi-key scans, debounces whole-scan
// results and presents a registered key code with a press pulse.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = KEYPAD_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = KEYPAD_DEBOUNCE_SCANS
) (
  input  logic      CLOCK_25,
  input  logic      reset_n,
  keypad_scanner_if.master kp
);

  localparam int         DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;
  localparam logic [1:0] COL3 = 2'd3;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'b00_00: k = 4'd1;
      4'b00_01: k = 4'd2;
      4'b00_10: k = 4'd3;
      4'b00_11: k = 4'd10;
      4'b01_00: k = 4'd4;
      4'b01_01: k = 4'd5;
      4'b01_10: k = 4'd6;
      4'b01_11: k = 4'd11;
      4'b10_00: k = 4'd7;
      4'b10_01: k = 4'd8;
      4'b10_10: k = 4'd9;
      4'b10_11: k = 4'd12;
      4'b11_00: k = 4'd14;
      4'b11_01: k = 4'd0;
      4'b11_10: k = 4'd15;
      default:  k = 4'd13;
    endcase
    return k;
  endfunction

  logic [3:0]       row_sync_n;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       code_q, code_d;
  raw_t             prev_q, prev_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       keys_q, keys_d;
  logic             valid_q, valid_d;
  logic             pressed_q, pressed_d;

  logic [3:0] rows;
  logic [2:0] col_cnt;
  logic [1:0] row_idx;
  logic [2:0] hits_sum;
  logic [1:0] hits_new;
  logic [3:0] code_new;
  logic       sample;
  raw_t       raw;
  raw_t       committed;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
    .clk   (CLOCK_25),
    .rst_n (reset_n),
    .d_i   (kp.row_n),
    .q_o   (row_sync_n)
  );

  assign committed = '{hit: valid_q, code: keys_q};
  assign sample    = (div_q == DIV_LAST);

  // Fold the current column into the running scan; hit count saturates at 2.
  always_comb begin
    rows    = ~row_sync_n;
    col_cnt = 3'd0;
    row_idx = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (rows[r]) begin
        col_cnt = col_cnt + 3'd1;
        row_idx = 2'(r);
      end
    end
    hits_sum = {1'b0, hits_q} + col_cnt;
    hits_new = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_new = (col_cnt == 3'd1) ? key_lookup(row_idx, col_q) : code_q;
    raw.hit  = (hits_new == 2'd1);
    raw.code = raw.hit ? code_new : KEY_NONE;
  end

  // NOTE: every next-state signal gets a default first, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    div_d     = div_q + DIV_W'(1);
    col_d     = col_q;
    col_n_d   = col_n_q;
    hits_d    = hits_q;
    code_d    = code_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    keys_d    = keys_q;
    valid_d   = valid_q;
    pressed_d = 1'b0;
    if (sample) begin
      div_d   = '0;
      col_d   = col_q + 2'd1;
      col_n_d = ~(4'b0001 << col_d);
      hits_d  = hits_new;
      code_d  = code_new;
      if (col_q == COL3) begin
        hits_d = 2'd0;
        code_d = KEY_NONE;
        if (raw == prev_q) begin
          if (cnt_q < DEB_MAX) cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d  = 4'd1;
          prev_d = raw;
        end
        if (cnt_d == DEB_MAX && raw != committed) begin
          keys_d    = raw.code;
          valid_d   = raw.hit;
          pressed_d = raw.hit;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (!reset_n) begin
      div_q     <= '0;
      col_q     <= COL0;
      col_n_q   <= 4'b1110;
      hits_q    <= 2'd0;
      code_q    <= KEY_NONE;
      prev_q    <= RAW_NONE;
      cnt_q     <= 4'd0;
      keys_q    <= KEY_NONE;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      col_n_q   <= col_n_d;
      hits_q    <= hits_d;
      code_q    <= code_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      keys_q    <= keys_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  end

  assign kp.col_n       = col_n_q;
  assign kp.keys        = keys_q;
  assign kp.key_valid   = valid_q;
  assign kp.key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix model of the keypad
// (SCAN_DIV=4, DEBOUNCE_SCANS=3, 16-cycle scan period).
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] held  = '0;
  logic [3:0]  row_model;
  int          total = 0;
  int          bad   = 0;
  int          pulses = 0;
  int          base;
  int          lat;
  int          valid_drops;
  int          valid_seen;
  logic [3:0]  exp_col;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .CLOCK_25 (clk),
    .reset_n  (rst_n),
    .kp       (kp)
  );

  always #5 clk = ~clk;

  // Closed switch at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !kp.col_n[c]) row_model[r] = 1'b0;
  end
  assign kp.row_n = row_model;

  always @(posedge clk) if (kp.key_pressed === 1'b1) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input logic lvl, output int n);
    n = 0;
    while (kp.key_valid !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    tick(3);
    check("rst_col_n", kp.col_n, 4'b1110);
    check("rst_keys", kp.keys, 4'd0);
    check("rst_valid", kp.key_valid, 1'b0);
    check("rst_pressed", kp.key_pressed, 1'b0);

    // Idle scanning: each column held low for 4 cycles, in order.
    rst_n = 1'b1;
    lat = 0;
    while (kp.col_n !== 4'b1101 && lat < 50) begin
      tick(1);
      lat++;
    end
    check("col_align", kp.col_n, 4'b1101);
    for (int g = 0; g < 8; g++) begin
      exp_col = ~(4'b0001 << ((g + 1) % 4));
      for (int s = 0; s < 4; s++) begin
        check("col_seq", kp.col_n, exp_col);
        tick(1);
      end
    end
    tick(30);
    check("idle_keys", kp.keys, 4'd0);
    check("idle_valid", kp.key_valid, 1'b0);
    check("idle_pulses", pulses, 0);

    // Clean press and release of "2" (r0/c1).
    base = pulses;
    held[1] = 1'b1;
    wait_valid(1'b1, lat);
    check("press2_latency_ok", (lat > 32 && lat <= 67), 1'b1);
    check("press2_keys", kp.keys, KEY_UP);
    tick(40);
    check("press2_hold_keys", kp.keys, KEY_UP);
    check("press2_pulses", pulses - base, 1);
    base = pulses;
    held[1] = 1'b0;
    wait_valid(1'b0, lat);
    check("release2_latency_ok", (lat > 32 && lat <= 67), 1'b1);
    check("release2_keys", kp.keys, KEY_NONE);
    tick(4);
    check("release2_no_pulse", pulses - base, 0);

    // "8" (r2/c1) bouncing every 5 cycles, then held.
    base = pulses;
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      held[9] = ~held[9];
      for (int s = 0; s < 5; s++) begin
        tick(1);
        if (kp.key_valid === 1'b1) valid_seen++;
      end
    end
    check("bounce_no_commit", valid_seen, 0);
    held[9] = 1'b1;
    wait_valid(1'b1, lat);
    check("bounce8_latency_ok", (lat <= 67), 1'b1);
    check("bounce8_keys", kp.keys, KEY_DOWN);
    tick(4);
    check("bounce8_pulses", pulses - base, 1);
    held[9] = 1'b0;
    wait_valid(1'b0, lat);
    check("release8_valid", kp.key_valid, 1'b0);

    // "2" and "5" together are rejected; dropping "5" commits "2".
    base = pulses;
    held[1] = 1'b1;
    held[5] = 1'b1;
    tick(100);
    check("multi_keys", kp.keys, KEY_NONE);
    check("multi_valid", kp.key_valid, 1'b0);
    check("multi_pulses", pulses - base, 0);
    held[5] = 1'b0;
    wait_valid(1'b1, lat);
    check("multi_release_latency_ok", (lat <= 67), 1'b1);
    check("multi_release_keys", kp.keys, KEY_UP);
    tick(4);
    check("multi_release_pulses", pulses - base, 1);

    // Direct change 2 -> 8 with a one-scan gap; no intermediate release.
    base = pulses;
    valid_drops = 0;
    held[1] = 1'b0;
    for (int s = 0; s < 16; s++) begin
      tick(1);
      if (kp.key_valid !== 1'b1) valid_drops++;
    end
    held[9] = 1'b1;
    lat = 0;
    while (kp.keys !== KEY_DOWN && lat < 120) begin
      tick(1);
      lat++;
      if (kp.key_valid !== 1'b1) valid_drops++;
    end
    check("change_keys", kp.keys, KEY_DOWN);
    check("change_valid_held", valid_drops, 0);
    tick(4);
    check("change_pulses", pulses - base, 1);

    // One-cycle reset in COL2 while "2" is committed.
    held[9] = 1'b0;
    wait_valid(1'b0, lat);
    held[1] = 1'b1;
    wait_valid(1'b1, lat);
    check("pre_reset_keys", kp.keys, KEY_UP);
    lat = 0;
    while (kp.col_n !== 4'b1011 && lat < 20) begin
      tick(1);
      lat++;
    end
    check("reset_in_col2", kp.col_n, 4'b1011);
    base = pulses;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("midrst_col_n", kp.col_n, 4'b1110);
    check("midrst_keys", kp.keys, KEY_NONE);
    check("midrst_valid", kp.key_valid, 1'b0);
    wait_valid(1'b1, lat);
    check("recommit_latency_ok", (lat <= 67), 1'b1);
    check("recommit_keys", kp.keys, KEY_UP);
    tick(4);
    check("recommit_pulses", pulses - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
